// File: rtl/md5_block_controller.sv
// MD5 block controller: one 512-bit block compressed in four cycles, one
// combinational 16-round group per cycle, chaining state kept in H.

module md5_round_group #(
    parameter int GRP = 0
) (
    input  logic [31:0]  a_in,
    input  logic [31:0]  b_in,
    input  logic [31:0]  c_in,
    input  logic [31:0]  d_in,
    input  logic [511:0] message,
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out
);
    localparam logic [31:0] K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam logic [4:0] S [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [127:0] run_group(input logic [127:0] st, input logic [511:0] m);
        logic [31:0] a, b, c, d, f, t;
        logic [63:0] rr;
        int          g;
        {a, b, c, d} = st;
        for (int r = 0; r < 16; r++) begin
            if (GRP == 0) begin
                f = (b & c) | (~b & d);
                g = r;
            end else if (GRP == 1) begin
                f = (d & b) | (~d & c);
                g = (5 * r + 1) % 16;
            end else if (GRP == 2) begin
                f = b ^ c ^ d;
                g = (3 * r + 5) % 16;
            end else begin
                f = c ^ (b | ~d);
                g = (7 * r) % 16;
            end
            t  = a + f + K[GRP*16 + r] + m[32*g +: 32];
            // upper half of the doubled word shifted left is the rotate-left
            rr = {t, t} << S[GRP*4 + r%4];
            a  = d;
            d  = c;
            c  = b;
            b  = b + rr[63:32];
        end
        return {a, b, c, d};
    endfunction

    assign {a_out, b_out, c_out, d_out} = run_group({a_in, b_in, c_in, d_in}, message);
endmodule

module MD5Rounds1To16 (
    input  logic [31:0] a_in, b_in, c_in, d_in,
    input  logic [511:0] message,
    output logic [31:0] a_out, b_out, c_out, d_out
);
    md5_round_group #(.GRP(0)) u_grp (.*);
endmodule

module MD5Rounds17To32 (
    input  logic [31:0] a_in, b_in, c_in, d_in,
    input  logic [511:0] message,
    output logic [31:0] a_out, b_out, c_out, d_out
);
    md5_round_group #(.GRP(1)) u_grp (.*);
endmodule

module MD5Rounds33To48 (
    input  logic [31:0] a_in, b_in, c_in, d_in,
    input  logic [511:0] message,
    output logic [31:0] a_out, b_out, c_out, d_out
);
    md5_round_group #(.GRP(2)) u_grp (.*);
endmodule

module MD5Rounds49To64 (
    input  logic [31:0] a_in, b_in, c_in, d_in,
    input  logic [511:0] message,
    output logic [31:0] a_out, b_out, c_out, d_out
);
    md5_round_group #(.GRP(3)) u_grp (.*);
endmodule

module md5_block_controller (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    input  logic         blk_first,
    input  logic [511:0] blk_data,
    output logic         blk_ready,
    output logic         digest_valid,
    output logic [127:0] digest_out
);
    localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

    typedef enum logic [2:0] {IDLE, G1, G2, G3, G4, DONE} state_t;
    state_t state, state_nxt;

    logic [511:0] msg;
    logic [127:0] w, h0, h, chain_in;
    logic [127:0] g1, g2, g3, g4;

    assign chain_in     = blk_first ? IV : h;
    assign blk_ready    = (state == IDLE) && !rst;
    assign digest_valid = (state == DONE);
    assign digest_out   = h;

    MD5Rounds1To16 u_g1 (.a_in(w[127:96]), .b_in(w[95:64]), .c_in(w[63:32]), .d_in(w[31:0]),
        .message(msg), .a_out(g1[127:96]), .b_out(g1[95:64]), .c_out(g1[63:32]), .d_out(g1[31:0]));
    MD5Rounds17To32 u_g2 (.a_in(w[127:96]), .b_in(w[95:64]), .c_in(w[63:32]), .d_in(w[31:0]),
        .message(msg), .a_out(g2[127:96]), .b_out(g2[95:64]), .c_out(g2[63:32]), .d_out(g2[31:0]));
    MD5Rounds33To48 u_g3 (.a_in(w[127:96]), .b_in(w[95:64]), .c_in(w[63:32]), .d_in(w[31:0]),
        .message(msg), .a_out(g3[127:96]), .b_out(g3[95:64]), .c_out(g3[63:32]), .d_out(g3[31:0]));
    MD5Rounds49To64 u_g4 (.a_in(w[127:96]), .b_in(w[95:64]), .c_in(w[63:32]), .d_in(w[31:0]),
        .message(msg), .a_out(g4[127:96]), .b_out(g4[95:64]), .c_out(g4[63:32]), .d_out(g4[31:0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            h     <= IV;
            h0    <= '0;
            w     <= '0;
            msg   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (blk_valid) begin
                    msg <= blk_data;
                    w   <= chain_in;
                    h0  <= chain_in;
                end
                G1: w <= g1;
                G2: w <= g2;
                G3: w <= g3;
                G4: h <= {h0[127:96] + g4[127:96], h0[95:64] + g4[95:64],
                          h0[63:32]  + g4[63:32],  h0[31:0]  + g4[31:0]};
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (blk_valid) state_nxt = G1;
            G1:      state_nxt = G2;
            G2:      state_nxt = G3;
            G3:      state_nxt = G4;
            G4:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_md5_block_controller.sv
// Directed bench for md5_block_controller: known MD5 vectors, chaining,
// busy-time input rejection and mid-block reset.

module tb_md5_block_controller;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_first = 1'b0;
    logic [511:0] blk_data = '0;
    logic         blk_ready, digest_valid;
    logic [127:0] digest_out;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] IV      = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    localparam logic [127:0] D_EMPTY = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
    localparam logic [127:0] D_ABC   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;

    localparam logic [31:0] KT [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int SH [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

    always #5 clk = ~clk;

    md5_block_controller dut (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_first(blk_first), .blk_data(blk_data),
        .blk_ready(blk_ready), .digest_valid(digest_valid), .digest_out(digest_out)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference MD5 compression: 64 steps on one block, then feed-forward add.
    function automatic logic [127:0] md5_model(input logic [127:0] hin, input logic [511:0] m);
        logic [31:0] a, b, c, d, f, t, tmp;
        int g, n;
        {a, b, c, d} = hin;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i; end
                1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
            endcase
            n   = SH[i/16][i%4];
            t   = a + f + KT[i] + m[32*g +: 32];
            tmp = d;
            d   = c;
            c   = b;
            b   = b + ((t << n) | (t >> (32 - n)));
            a   = tmp;
        end
        return {hin[127:96] + a, hin[95:64] + b, hin[63:32] + c, hin[31:0] + d};
    endfunction

    // Offer one block from IDLE and wait for its digest; with hold set, keep
    // blk_valid high with junk data while busy to prove it is ignored.
    task automatic send(input logic [511:0] data, input logic first, input logic hold,
                        input logic [127:0] exp, input string tag);
        logic [127:0] prev;
        int lat;
        @(negedge clk);
        prev = digest_out;
        chk({tag, "_rdy_idle"}, 128'(blk_ready), 128'd1);
        blk_valid = 1'b1;
        blk_data  = data;
        blk_first = first;
        lat = 0;
        @(negedge clk);
        if (!hold) blk_valid = 1'b0;
        while (!digest_valid && lat < 20) begin
            chk({tag, "_h_hold"}, digest_out, prev);
            if (hold) begin
                chk({tag, "_rdy_busy"}, 128'(blk_ready), 128'd0);
                blk_data  = {16{$urandom()}};
                blk_first = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd4);
        chk({tag, "_digest"}, digest_out, exp);
        if (hold) chk({tag, "_rdy_done"}, 128'(blk_ready), 128'd0);
        blk_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_dv_pulse"}, 128'(digest_valid), 128'd0);
        chk({tag, "_rdy_back"}, 128'(blk_ready), 128'd1);
        chk({tag, "_digest_keep"}, digest_out, exp);
    endtask

    logic [511:0] b_empty, b_abc, b_a64, b_pad;
    logic [127:0] e1, e2;

    initial begin
        b_empty = '0; b_empty[31:0] = 32'h00000080;
        b_abc   = '0; b_abc[31:0]   = 32'h80636261; b_abc[14*32 +: 32] = 32'h00000018;
        b_a64   = {16{32'h61616161}};
        b_pad   = '0; b_pad[31:0]   = 32'h00000080; b_pad[14*32 +: 32] = 32'h00000200;

        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(blk_ready), 128'd0);
        chk("rst_dv", 128'(digest_valid), 128'd0);
        chk("rst_digest", digest_out, IV);
        rst = 1'b0;
        #1 chk("rst_release_ready", 128'(blk_ready), 128'd1);

        send(b_empty, 1'b1, 1'b0, D_EMPTY, "empty");
        send(b_abc, 1'b1, 1'b0, D_ABC, "abc");
        send(b_abc, 1'b1, 1'b0, D_ABC, "abc_again");

        e1 = md5_model(IV, b_a64);
        e2 = md5_model(e1, b_pad);
        send(b_a64, 1'b1, 1'b0, e1, "two_blk_1");
        send(b_pad, 1'b0, 1'b0, e2, "two_blk_2");
        send(b_a64, 1'b1, 1'b0, e1, "restart_iv");

        send(b_empty, 1'b1, 1'b1, D_EMPTY, "busy_hold");

        // reset while the third round group is active
        @(negedge clk);
        blk_valid = 1'b1; blk_data = b_abc; blk_first = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 128'(blk_ready), 128'd0);
        chk("midrst_dv", 128'(digest_valid), 128'd0);
        chk("midrst_digest", digest_out, IV);
        rst = 1'b0;
        #1 chk("midrst_release_ready", 128'(blk_ready), 128'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_dv", 128'(digest_valid), 128'd0);
        end
        chk("midrst_digest_iv", digest_out, IV);
        send(b_empty, 1'b1, 1'b0, D_EMPTY, "post_rst_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
